// File: rtl/dnn_pkg.sv
// Shared types and helpers for the training sequencer: FSM states, direction
// codes, default widths and the saturating subtract used for the loss.
package dnn_pkg;

   localparam int DW_DEF         = 19;
   localparam int NUM_LAYERS_DEF = 5;
   localparam int EPOCH_W_DEF    = 8;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_BWD = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FWD_ISSUE,
      S_FWD_WAIT,
      S_LOSS,
      S_BWD_ISSUE,
      S_BWD_WAIT,
      S_COMMIT,
      S_NEXT,
      S_FINISH
   } state_t;

   // a - b clamped to the signed range of a w-bit word (w <= 32); the
   // difference is formed one bit wider so it cannot overflow first.
   function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int w);
      logic signed [32:0] d;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      d  = 33'(a) - 33'(b);
      hi = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 1));
      if (d > hi)
         d = hi;
      else if (d < lo)
         d = lo;
      return d[31:0];
   endfunction

endpackage

// File: rtl/dnn_loss_sat.sv
// Registered saturating loss: q <= clamp(a - b) into DW signed bits when en is high.
module dnn_loss_sat
   import dnn_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [DW-1:0] q
);

   logic signed [DW-1:0] q_next;

   assign q_next = DW'(sat_sub(32'(a), 32'(b), DW));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q <= '0;
      else if (en)
         q <= q_next;
   end

endmodule

// File: rtl/dnn_train_sequencer.sv
// Sequences one shared layer engine through forward, loss, backward and weight
// commit phases for a requested number of epochs.
module dnn_train_sequencer
   import dnn_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int NUM_LAYERS = NUM_LAYERS_DEF,
   parameter int EPOCH_W    = EPOCH_W_DEF,
   localparam int LW        = $clog2(NUM_LAYERS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [EPOCH_W-1:0]   epochs,
   input  logic signed [DW-1:0] target,
   output logic                 eng_start,
   output logic [LW-1:0]        eng_layer,
   output logic                 eng_dir,
   input  logic                 eng_done,
   input  logic signed [DW-1:0] eng_result,
   output logic                 wr_commit,
   output logic signed [DW-1:0] pred,
   output logic signed [DW-1:0] loss,
   output logic [EPOCH_W-1:0]   epoch_cnt,
   output logic                 busy,
   output logic                 done,
   output logic                 converged
);

   localparam logic [LW-1:0] LAST = LW'(NUM_LAYERS - 1);

   state_t               state;
   logic [LW-1:0]        layer;
   logic [EPOCH_W-1:0]   epochs_q;
   logic [EPOCH_W-1:0]   cnt_next;
   logic signed [DW-1:0] tgt;
   logic                 loss_en;

   assign eng_layer = layer;
   assign cnt_next  = epoch_cnt + 1'b1;
   assign loss_en   = (state == S_LOSS) && !abort;

   dnn_loss_sat #(.DW(DW)) u_loss (
      .clk   (clk),
      .reset (reset),
      .en    (loss_en),
      .a     (tgt),
      .b     (pred),
      .q     (loss)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         layer     <= '0;
         epochs_q  <= '0;
         tgt       <= '0;
         eng_start <= 1'b0;
         eng_dir   <= DIR_FWD;
         wr_commit <= 1'b0;
         pred      <= '0;
         epoch_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         converged <= 1'b0;
      end else begin
         // strobes are single-cycle unless re-armed below
         eng_start <= 1'b0;
         wr_commit <= 1'b0;
         done      <= 1'b0;
         if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     epochs_q  <= epochs;
                     tgt       <= target;
                     epoch_cnt <= '0;
                     converged <= 1'b0;
                     busy      <= 1'b1;
                     if (epochs == '0) begin
                        done  <= 1'b1;
                        state <= S_FINISH;
                     end else begin
                        layer     <= '0;
                        eng_dir   <= DIR_FWD;
                        eng_start <= 1'b1;
                        state     <= S_FWD_ISSUE;
                     end
                  end
               end
               S_FWD_ISSUE: state <= S_FWD_WAIT;
               S_FWD_WAIT: begin
                  if (eng_done) begin
                     if (layer < LAST) begin
                        layer     <= layer + 1'b1;
                        eng_start <= 1'b1;
                        state     <= S_FWD_ISSUE;
                     end else begin
                        pred  <= eng_result;
                        state <= S_LOSS;
                     end
                  end
               end
               S_LOSS: begin
                  // zero loss iff target == prediction, so no need to wait for the register
                  if (tgt == pred) begin
                     converged <= 1'b1;
                     done      <= 1'b1;
                     state     <= S_FINISH;
                  end else begin
                     layer     <= LAST;
                     eng_dir   <= DIR_BWD;
                     eng_start <= 1'b1;
                     state     <= S_BWD_ISSUE;
                  end
               end
               S_BWD_ISSUE: state <= S_BWD_WAIT;
               S_BWD_WAIT: begin
                  if (eng_done) begin
                     if (layer != '0) begin
                        layer     <= layer - 1'b1;
                        eng_start <= 1'b1;
                        state     <= S_BWD_ISSUE;
                     end else begin
                        wr_commit <= 1'b1;
                        state     <= S_COMMIT;
                     end
                  end
               end
               S_COMMIT: state <= S_NEXT;
               S_NEXT: begin
                  epoch_cnt <= cnt_next;
                  if (cnt_next == epochs_q) begin
                     done  <= 1'b1;
                     state <= S_FINISH;
                  end else begin
                     layer     <= '0;
                     eng_dir   <= DIR_FWD;
                     eng_start <= 1'b1;
                     state     <= S_FWD_ISSUE;
                  end
               end
               S_FINISH: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
